// File: rtl/frame_rx_if.sv
// rtl/frame_rx_if.sv - serial line and result bus between frame transmitter and frame_rx
interface frame_rx_if #(
  parameter int DATA_W = 128
);
  logic                  rx;
  logic [DATA_W/2-1:0]   sayi1;
  logic [DATA_W/2-1:0]   sayi2;
  logic [7:0]            rx_checksum;
  logic                  frame_valid;
  logic                  chk_err;
  logic                  hdr_err;
  logic                  busy;

  modport master (
    output rx,
    input  sayi1, sayi2, rx_checksum, frame_valid, chk_err, hdr_err, busy
  );

  modport slave (
    input  rx,
    output sayi1, sayi2, rx_checksum, frame_valid, chk_err, hdr_err, busy
  );
endinterface

// File: rtl/frame_rx.sv
// rtl/frame_rx.sv - bit-serial frame receiver: start, header, payload, checksum, LSB first
// Optional RX_SYNC_EN: 2-FF input synchronizer on rx, shifting all timings by +2 cycles.
module frame_rx #(
  parameter logic [15:0] HEADER = 16'hBACD,
  parameter int          DATA_W = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  frame_rx_if.slave  bus
);
  localparam int HALF  = DATA_W / 2;
  localparam int CNT_W = ($clog2(DATA_W) > 4) ? $clog2(DATA_W) : 4;

  typedef enum logic [1:0] {IDLE, HDR, DATA, CHK} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [15:0]         hdr_q;
  logic [DATA_W-1:0]   payload_q;
  logic [7:0]          chk_q;
  logic [HALF-1:0]     sayi1_q;
  logic [HALF-1:0]     sayi2_q;
  logic [7:0]          rx_checksum_q;
  logic                frame_valid_q;
  logic                chk_err_q;
  logic                hdr_err_q;
  logic                rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], bus.rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = bus.rx;
`endif

  // Words as they will look once the bit being sampled this edge is shifted in.
  logic [15:0] hdr_word_d;
  logic [7:0]  chk_byte_d;
  logic [7:0]  chk_exp_d;
  always_comb begin
    hdr_word_d = {rx_s, hdr_q[15:1]};
    chk_byte_d = {rx_s, chk_q[7:1]};
    chk_exp_d  = payload_q[HALF+7:HALF] + payload_q[7:0] + hdr_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hdr_q         <= '0;
      payload_q     <= '0;
      chk_q         <= '0;
      sayi1_q       <= '0;
      sayi2_q       <= '0;
      rx_checksum_q <= '0;
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
      hdr_err_q     <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
      hdr_err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= HDR;
            cnt_q   <= '0;
          end
        end
        HDR: begin
          hdr_q <= hdr_word_d;
          if (cnt_q == CNT_W'(15)) begin
            cnt_q <= '0;
            if (hdr_word_d != HEADER) begin
              hdr_err_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q   <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          payload_q <= {rx_s, payload_q[DATA_W-1:1]};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_q   <= '0;
            state_q <= CHK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CHK: begin
          chk_q <= chk_byte_d;
          if (cnt_q == CNT_W'(7)) begin
            cnt_q         <= '0;
            rx_checksum_q <= chk_byte_d;
            state_q       <= IDLE;
            if (chk_byte_d == chk_exp_d) begin
              sayi1_q       <= payload_q[DATA_W-1:HALF];
              sayi2_q       <= payload_q[HALF-1:0];
              frame_valid_q <= 1'b1;
            end else begin
              chk_err_q     <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sayi1       = sayi1_q;
  assign bus.sayi2       = sayi2_q;
  assign bus.rx_checksum = rx_checksum_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.chk_err     = chk_err_q;
  assign bus.hdr_err     = hdr_err_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_frame_rx.sv
// tb/tb_frame_rx.sv - randomized scoreboard bench for frame_rx
module tb_frame_rx;
  localparam logic [15:0] HDR_OK = 16'hBACD;
`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int          kind;   // 0 valid, 1 chk_err, 2 hdr_err
    longint      cyc;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [7:0]  cks;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  exp_t   q[$];
  logic [63:0] m_s1 = '0, m_s2 = '0;
  logic [7:0]  m_cks = '0;

  frame_rx_if bus ();
  frame_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame's outcome follows from header and modular sum.
  task automatic send_frame(input logic [15:0] hdr, input logic [63:0] s1,
                            input logic [63:0] s2, input logic [7:0] cks);
    logic [152:0] bits;
    int   n;
    exp_t e;
    bits = {cks, s1, s2, hdr, 1'b0};
    n = (hdr == HDR_OK) ? 153 : 17;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hdr != HDR_OK) e.kind = 2;
        else if (cks == 8'((s1 + s2 + 64'(hdr)) % 256)) e.kind = 0;
        else e.kind = 1;
        if (e.kind == 0) begin m_s1 = s1; m_s2 = s2; end
        if (e.kind != 2) m_cks = cks;
        e.cyc = cyc + n + LAT;
        e.s1 = m_s1; e.s2 = m_s2; e.cks = m_cks;
        q.push_back(e);
      end
      bus.rx = bits[k];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) bus.rx = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_sayi1"}, bus.sayi1, 64'h0);
    cmp({tag, "_sayi2"}, bus.sayi2, 64'h0);
    cmp({tag, "_cks"}, {56'h0, bus.rx_checksum}, 64'h0);
    cmp({tag, "_pulses"}, {61'h0, bus.frame_valid, bus.chk_err, bus.hdr_err}, 64'h0);
    cmp({tag, "_busy"}, {63'h0, bus.busy}, 64'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_valid || bus.chk_err || bus.hdr_err) begin
        cmp("pulse_onehot", {62'h0, 2'(int'(bus.frame_valid) + int'(bus.chk_err) + int'(bus.hdr_err))}, 64'h1);
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          int kind;
          e = q.pop_front();
          kind = bus.frame_valid ? 0 : (bus.chk_err ? 1 : 2);
          cmp("kind", 64'(kind), 64'(e.kind));
          cmp("pulse_cycle", 64'(cyc), 64'(e.cyc));
          cmp("sayi1", bus.sayi1, e.s1);
          cmp("sayi2", bus.sayi2, e.s2);
          cmp("rx_checksum", {56'h0, bus.rx_checksum}, {56'h0, e.cks});
          cmp("busy_at_pulse", {63'h0, bus.busy}, 64'h0);
        end
      end
      if (q.size() != 0 && q[0].cyc < cyc) begin
        n_vec++; n_err++;
        $display("FAIL missed_pulse: got none expected kind %0d at cycle %0d", q[0].kind, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    idle(5);

    send_frame(HDR_OK, 64'h1, 64'h2, 8'hD0);
    idle(3);
    send_frame(HDR_OK, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'hCD);
    idle(2);
    send_frame(HDR_OK, 64'h1, 64'h2, 8'hD1);
    idle(4);
    send_frame(16'hBACE, 64'h0, 64'h0, 8'h0);
    idle(2);
    send_frame(HDR_OK, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 8'h0E);
    idle(3);
    send_frame(HDR_OK, 64'h10, 64'h20, 8'hFD);
    send_frame(HDR_OK, 64'hAB, 64'h01, 8'h79);
    idle(3);
    send_frame(16'h0000, 64'h0, 64'h0, 8'h0);
    send_frame(16'h0000, 64'h0, 64'h0, 8'h0);
    idle(4 + LAT);

    // Abort mid-payload: bits 0..86 sent, reset where payload bit 70 would go.
    begin
      logic [152:0] bits;
      bits = {8'hD0, 64'h5, 64'h6, HDR_OK, 1'b0};
      for (int k = 0; k < 87; k++) begin
        @(negedge clk);
        bus.rx = bits[k];
      end
      @(negedge clk);
      rst_n = 1'b0;
      bus.rx = 1'b1;
      m_s1 = '0; m_s2 = '0; m_cks = '0;
      #1 check_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    idle(4);
    send_frame(HDR_OK, 64'h7, 64'h8, 8'hDC);
    idle(2);

    for (int i = 0; i < 20; i++) begin
      logic [63:0] s1, s2;
      logic [15:0] h;
      logic [7:0]  c;
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      h  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : HDR_OK;
      c  = 8'((s1 + s2 + 64'(h)) % 256);
      if ($urandom_range(0, 2) == 0) c = 8'($urandom);
      send_frame(h, s1, s2, c);
      idle($urandom_range(0, 2));
    end

    for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_rx.md
Name: frame_rx

Overview:
Bit-serial frame receiver that sits directly downstream of the team's frame transmitter, on the same clock. It deserializes one bit per clock:
- start bit
- 16-bit header, LSB first
- 128-bit payload {sayi1,sayi2}, LSB first (sayi2[0] first)
- 8-bit checksum, LSB first

It checks the header and checksum, then presents the two 64-bit operands with a one-cycle valid pulse.

Parameters:
HEADER, 16'hBACD, expected header word; any other value aborts the frame.
DATA_W, 128, payload width in bits; sayi1 = upper half, sayi2 = lower half.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx  input  1  serial line; idles high; one bit per clk.
sayi1  output  64  payload[127:64] of the last good frame.
sayi2  output  64  payload[63:0] of the last good frame.
rx_checksum  output  8  checksum field of the last completed frame, good or bad.
frame_valid  output  1  one-cycle pulse: frame accepted, sayi1/sayi2 updated.
chk_err  output  1  one-cycle pulse: checksum mismatch.
hdr_err  output  1  one-cycle pulse: header mismatch.
busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sayi1, sayi2, rx_checksum = 0.
  - frame_valid, chk_err, hdr_err, busy = 0.
  - All counters and shift registers = 0.
- Frame timing: edge k samples frame bit k.
  - k=0: start bit (0).
  - k=1..16: header.
  - k=17..144: payload.
  - k=145..152: checksum.
  - Total frame = 153 bits.
- States:
  - IDLE: rx==0 -> HDR, bit counter=0. rx==1 -> stay.
  - HDR: shift rx into hdr[cnt]. On 16th bit, compare the complete word including this bit against HEADER.
    - Mismatch: hdr_err=1 for 1 cycle, -> IDLE.
    - Match: -> DATA.
  - DATA: payload[cnt] <= rx, cnt 0..127. After bit 127 -> CHK.
  - CHK: chk[cnt] <= rx, cnt 0..7. On the edge sampling bit 7:
    - rx_checksum <= the full received byte.
    - Compute expected = (payload[127:64] + payload[63:0] + hdr) mod 256, i.e. payload[71:64] + payload[7:0] + hdr[7:0], 8-bit wrap.
    - Equal: sayi1/sayi2 <= payload halves, frame_valid=1.
    - Not equal: chk_err=1; sayi1/sayi2 hold their old values.
    - -> IDLE in the same edge.
- Latency: outputs and pulses are visible right after edge 152, i.e. 0 cycles after the last checksum bit is sampled.
- Back-to-back: the transmitter may send a new start bit on the cycle right after the last checksum bit. IDLE must sample it at edge 153; no stop bit is required.
- rx stuck low: treated as a start. Header reads 16'h0000, so hdr_err fires at edge 16, then the cycle repeats.
- Pulse rules: frame_valid, chk_err and hdr_err are mutually exclusive and never high for more than 1 consecutive cycle.
- Reset mid-frame: immediate abort, no pulse; the partial frame is discarded.
- busy=0 only in IDLE.

Optional Feature:
RX_SYNC_EN
- Defined: rx passes through a 2-FF synchronizer (reset value 1) before the state machine. All sample edges, and therefore all output timings, shift by +2 cycles.
- Undefined: rx is sampled directly; same-clock use only.

Test Plan:
- Good frame: header BACD, sayi1=64'h1, sayi2=64'h2, checksum 8'hD0 -> frame_valid at edge 152, sayi1=1, sayi2=2, rx_checksum=D0, no errors.
- Wrap: sayi1=64'hFFFF_FFFF_FFFF_FFFF, sayi2=64'h1, checksum 8'hCD -> frame_valid, sayi1 all-ones, sayi2=1.
- Bad checksum: first frame's payload with checksum 8'hD1 -> chk_err pulse, rx_checksum=D1, sayi1/sayi2 keep the previous good values.
- Bad header: header 16'hBACE -> hdr_err at edge 16, busy drops; a following good frame is accepted.
- Back-to-back: two good frames with no idle gap (frame 2 start bit at edge 153) -> two frame_valid pulses 153 cycles apart, second payload on the outputs.
- Reset mid-frame: assert rst_n=0 at payload bit 70 -> all outputs 0 immediately, no pulse; a good frame after release is accepted normally.
